// File: rtl/bcd_counter_n.sv
// bcd_counter_n
//
// Multi-digit decimal counter for the lab display path. Holds a DIGITS-wide
// packed BCD value that steps up or down once every PRESCALE enabled cycles.
// It supports synchronous clear and parallel load, and flags rollover. It also
// produces per-digit codes for the SevenSeg decoder, with optional
// leading-zero blanking.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset_n      asynchronous active-low reset
//   en           counting enable, gates the prescaler
//   up           direction: 1 counts up, 0 counts down
//   clear        synchronous clear to zero (highest priority)
//   load         synchronous parallel load from load_bcd
//   load_bcd     packed BCD load value, digit 0 in bits [3:0]
//   lzb          leading-zero blanking enable
//   count_bcd    registered packed BCD count
//   digit_codes  SevenSeg NUM codes, digit i in bits [8i+7:8i]
//   step         one-cycle pulse when a count step was applied
//   wrap         one-cycle pulse on rollover (past all-9s or below zero)
//   load_err     one-cycle pulse when a load contained a non-BCD digit

module bcd_counter_n #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                up,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_bcd,
    input  logic                lzb,
    output logic [4*DIGITS-1:0] count_bcd,
    output logic [8*DIGITS-1:0] digit_codes,
    output logic                step,
    output logic                wrap,
    output logic                load_err
);

    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
    localparam logic [7:0]    BLANK_CODE = 8'd88;

    logic [PW-1:0]       pre;
    logic                tick;
    logic [4*DIGITS-1:0] count_next;
    logic                roll;
    logic [4*DIGITS-1:0] load_clean;
    logic                load_bad;

    // With PRESCALE=1 the prescaler stays at 0, so tick reduces to en.
    assign tick = en && (pre == PRE_LAST);

    // Digit-serial carry/borrow chain. The chain enters digit 0 set. It keeps
    // propagating only while digits wrap (9->0 going up, 0->9 going down).
    // If it leaves the top digit still set, the whole value rolled over.
    always_comb begin
        logic chain;
        count_next = count_bcd;
        chain      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (chain) begin
                if (up) begin
                    if (count_bcd[4*i +: 4] == 4'd9) begin
                        count_next[4*i +: 4] = 4'd0;
                    end else begin
                        count_next[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                        chain                = 1'b0;
                    end
                end else begin
                    if (count_bcd[4*i +: 4] == 4'd0) begin
                        count_next[4*i +: 4] = 4'd9;
                    end else begin
                        count_next[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
                        chain                = 1'b0;
                    end
                end
            end
        end
        roll = chain;
    end

    // Non-BCD load digits are replaced by 0 and flagged, so no digit in the
    // count ever holds a value above 9.
    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_bcd[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_bcd[4*i +: 4];
            end
        end
    end

    // Scan from the most significant digit downward. A digit is blanked while
    // it and every digit above it are zero. Digit 0 always shows.
    always_comb begin
        logic leading_zero;
        digit_codes  = '0;
        leading_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            leading_zero = leading_zero && (count_bcd[4*i +: 4] == 4'd0);
            if (lzb && (i != 0) && leading_zero) begin
                digit_codes[8*i +: 8] = BLANK_CODE;
            end else begin
                digit_codes[8*i +: 8] = {4'd0, count_bcd[4*i +: 4]};
            end
        end
    end

    // Priority is clear > load > tick > hold. Clear and load both restart the
    // prescaler, and a load discards a coincident tick. Pulses default low so
    // each one lasts exactly one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_bcd <= '0;
            pre       <= '0;
            step      <= 1'b0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            step     <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clear) begin
                count_bcd <= '0;
                pre       <= '0;
            end else if (load) begin
                count_bcd <= load_clean;
                pre       <= '0;
                load_err  <= load_bad;
            end else begin
                if (en) begin
                    pre <= tick ? '0 : pre + PW'(1);
                end
                if (tick) begin
                    count_bcd <= count_next;
                    step      <= 1'b1;
                    wrap      <= roll;
                end
            end
        end
    end

endmodule
